// File: rtl/seq_lookahead_divider.sv
// Iterative restoring divider that produces one quotient bit per clock.
// Each trial subtraction is rem + ~divisor + 1, with carries taken from
// chained 4-bit carry-lookahead groups.
// Optional build macro: SIGNED_DIV_EN (two's-complement operands; the sign is
// fixed up on the transition into DONE).
module seq_lookahead_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned NumGroups = WIDTH / 4;
    localparam int unsigned CntW      = $clog2(WIDTH + 1);

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
        $error("seq_lookahead_divider: WIDTH must be a multiple of 4 and at least 4");
    end

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e            state_q;
    logic [CntW-1:0]   count_q;
    logic [WIDTH-1:0]  rem_q;
    logic [WIDTH-1:0]  quo_q;
    logic [WIDTH-1:0]  dvs_q;
    logic [WIDTH-1:0]  quotient_q;
    logic [WIDTH-1:0]  remainder_q;
    logic              dbz_q;

    // Datapath signals for one iteration
    logic [WIDTH-1:0]  a_lo;
    logic [WIDTH-1:0]  nb;
    logic [WIDTH-1:0]  diff;
    logic [WIDTH:0]    carry;
    logic              no_borrow;
    logic [WIDTH-1:0]  rem_nx;
    logic [WIDTH-1:0]  quo_nx;

    // Values latched on accept and results written on entry to DONE
    logic [WIDTH-1:0]  acc_dd;
    logic [WIDTH-1:0]  acc_dv;
    logic [WIDTH-1:0]  fin_quo;
    logic [WIDTH-1:0]  fin_rem;

    // Shifted partial remainder: the top bit is rem_q[WIDTH-1], and the low bits
    // pick up the quotient MSB.
    assign a_lo = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    assign nb   = ~dvs_q;

    // Trial subtraction through chained 4-bit lookahead groups (carry-in 1).
    always_comb begin
        logic [3:0] gg;
        logic [3:0] pp;
        logic       ci;
        gg       = '0;
        pp       = '0;
        ci       = 1'b0;
        diff     = '0;
        carry    = '0;
        carry[0] = 1'b1;
        for (int k = 0; k < int'(NumGroups); k++) begin
            gg = a_lo[4*k +: 4] & nb[4*k +: 4];
            pp = a_lo[4*k +: 4] ^ nb[4*k +: 4];
            ci = carry[4*k];
            carry[4*k+1] = gg[0] | (pp[0] & ci);
            carry[4*k+2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & ci);
            carry[4*k+3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                         | (pp[2] & pp[1] & pp[0] & ci);
            carry[4*k+4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                         | (pp[3] & pp[2] & pp[1] & gg[0]) | ((&pp) & ci);
            for (int j = 0; j < 4; j++) begin
                diff[4*k+j] = pp[j] ^ carry[4*k+j];
            end
        end
    end

    // The top bit subtracts a zero-extended divisor bit (~0 = 1), so its
    // carry-out is a | c. A carry-out of 1 means there is no borrow.
    assign no_borrow = rem_q[WIDTH-1] | carry[WIDTH];
    assign rem_nx    = no_borrow ? diff : a_lo;
    assign quo_nx    = {quo_q[WIDTH-2:0], no_borrow};

`ifdef SIGNED_DIV_EN
    logic neg_quo_q;
    logic neg_rem_q;

    // Take the operand magnitudes on accept and apply the result signs at the end
    always_comb begin
        acc_dd  = dividend[WIDTH-1] ? -dividend : dividend;
        acc_dv  = divisor[WIDTH-1]  ? -divisor  : divisor;
        fin_quo = neg_quo_q ? -quo_nx : quo_nx;
        fin_rem = neg_rem_q ? -rem_nx : rem_nx;
    end

    // Sign flags for the operation in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (state_q == StIdle && in_valid) begin
            neg_quo_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem_q <= dividend[WIDTH-1];
        end
    end
`else
    // Unsigned operation passes operands and results through unchanged
    always_comb begin
        acc_dd  = dividend;
        acc_dv  = divisor;
        fin_quo = quo_nx;
        fin_rem = rem_nx;
    end
`endif

    // Control FSM with the datapath registers and registered result outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            count_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        rem_q <= '0;
                        quo_q <= acc_dd;
                        dvs_q <= acc_dv;
                        if (divisor == '0) begin
                            quotient_q  <= '1;
                            remainder_q <= dividend;
                            dbz_q       <= 1'b1;
                            state_q     <= StDone;
                        end else begin
                            count_q <= CntW'(WIDTH);
                            state_q <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    rem_q   <= rem_nx;
                    quo_q   <= quo_nx;
                    count_q <= count_q - CntW'(1);
                    if (count_q == CntW'(1)) begin
                        quotient_q  <= fin_quo;
                        remainder_q <= fin_rem;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        dbz_q   <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready    = (state_q == StIdle);
    assign out_valid   = (state_q == StDone);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
